// File: rtl/drac_pkg.sv
// Shared types for the EXE-stage iterative divider.
// FSM state encoding and the captured request bundle.
package drac_pkg;

    localparam int unsigned DIV_MAX_XLEN = 64;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        HOLD
    } div_state_t;

    typedef struct packed {
        logic                    int_32;
        logic                    signed_op;
        logic [DIV_MAX_XLEN-1:0] dvnd;
        logic [DIV_MAX_XLEN-1:0] dvsr;
    } div_req_t;

endpackage

// File: rtl/div_step.sv
// Cascaded restoring shift-subtract stages, one quotient bit each.
// Purely combinational; rmd stays below dvsr between stages.
module div_step #(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic [XLEN-1:0] rmd_i,
    input  logic [XLEN-1:0] dq_i,
    input  logic [XLEN-1:0] dvsr_i,
    output logic [XLEN-1:0] rmd_o,
    output logic [XLEN-1:0] dq_o
);

    logic [XLEN:0]   r;
    logic [XLEN-1:0] q;
    logic [XLEN:0]   d;

    always_comb begin
        d = {1'b0, dvsr_i};
        r = {1'b0, rmd_i};
        q = dq_i;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            r = {r[XLEN-1:0], q[XLEN-1]};
            q = {q[XLEN-2:0], 1'b0};
            if (r >= d) begin
                r    = r - d;
                q[0] = 1'b1;
            end
        end
        rmd_o = r[XLEN-1:0];
        dq_o  = q;
    end

endmodule

// File: rtl/iter_div_unit.sv
// Iterative integer divider for DIV/DIVU/REM/REMU and W variants.
// Valid/ready request and response, kill flushes in-flight work.
module iter_div_unit
    import drac_pkg::*;
#(
    parameter int unsigned XLEN           = 64,
    parameter int unsigned BITS_PER_CYCLE = 4,
    parameter bit          EARLY_OUT      = 1'b1
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            kill_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            int_32_i,
    input  logic            signed_op_i,
    input  logic [XLEN-1:0] dvnd_i,
    input  logic [XLEN-1:0] dvsr_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] quo_o,
    output logic [XLEN-1:0] rmd_o,
    output logic            busy_o
);

    localparam int unsigned CNT_W = $clog2(XLEN / BITS_PER_CYCLE + 1);
    localparam int unsigned LZ_W  = $clog2(XLEN + 1);

    div_state_t      state_q, state_d;
    div_req_t        req_q, req_d;
    logic [XLEN-1:0] rmd_q, rmd_d;
    logic [XLEN-1:0] dq_q, dq_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            quo_neg_q, quo_neg_d;
    logic            rmd_neg_q, rmd_neg_d;
    logic            special_q, special_d;
    logic [XLEN-1:0] res_quo_q, res_quo_d;
    logic [XLEN-1:0] res_rmd_q, res_rmd_d;

    logic            accept;
    logic            w32;
    logic            sgn;
    logic [XLEN-1:0] p_dvnd_e, p_dvsr_e;
    logic            p_dvnd_neg, p_dvsr_neg;
    logic [XLEN-1:0] p_dvnd_abs, p_dvsr_abs;
    logic [XLEN-1:0] p_min, p_aligned;
    logic            p_div0, p_ovf;
    logic [LZ_W-1:0] p_lz;
    logic [CNT_W-1:0] p_ngrp, p_grp_lz, p_skip;
    logic [XLEN-1:0] step_rmd, step_dq;
    logic [XLEN-1:0] q_raw, r_raw;

    function automatic logic [XLEN-1:0] ext32(
        input logic [XLEN-1:0] v,
        input logic            sx
    );
        logic [XLEN-1:0] r;
        r = v;
        for (int i = 32; i < int'(XLEN); i++) begin
            r[i] = sx & v[31];
        end
        return r;
    endfunction

    function automatic logic [LZ_W-1:0] lzc(input logic [XLEN-1:0] v);
        logic [LZ_W-1:0] n;
        logic            hit;
        n   = '0;
        hit = 1'b0;
        for (int i = int'(XLEN) - 1; i >= 0; i--) begin
            if (v[i]) hit = 1'b1;
            if (!hit) n = n + 1'b1;
        end
        return n;
    endfunction

    assign accept      = req_valid_i & req_ready_o & ~kill_i;
    assign req_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_valid_o = (state_q == HOLD);
    assign quo_o       = res_quo_q;
    assign rmd_o       = res_rmd_q;

    assign w32 = req_q.int_32;
    assign sgn = req_q.signed_op;

    // Operand conditioning, only consumed in PREP.
    always_comb begin
        p_dvnd_e = req_q.dvnd[XLEN-1:0];
        p_dvsr_e = req_q.dvsr[XLEN-1:0];
        if (w32) begin
            p_dvnd_e = ext32(req_q.dvnd[XLEN-1:0], sgn);
            p_dvsr_e = ext32(req_q.dvsr[XLEN-1:0], sgn);
        end
        p_dvnd_neg = sgn & p_dvnd_e[XLEN-1];
        p_dvsr_neg = sgn & p_dvsr_e[XLEN-1];
        p_dvnd_abs = p_dvnd_neg ? -p_dvnd_e : p_dvnd_e;
        p_dvsr_abs = p_dvsr_neg ? -p_dvsr_e : p_dvsr_e;
        p_min = w32 ? ~XLEN'(32'h7FFF_FFFF)
                    : {1'b1, {(XLEN-1){1'b0}}};
        p_div0 = (p_dvsr_e == '0);
        p_ovf  = sgn & (p_dvsr_e == '1) & (p_dvnd_e == p_min);
        p_aligned = w32 ? (p_dvnd_abs << (XLEN - 32)) : p_dvnd_abs;
        p_lz   = lzc(p_aligned);
        p_ngrp = w32 ? CNT_W'(32 / BITS_PER_CYCLE)
                     : CNT_W'(XLEN / BITS_PER_CYCLE);
        p_grp_lz = CNT_W'(p_lz / BITS_PER_CYCLE);
        p_skip   = '0;
        if (EARLY_OUT) begin
            p_skip = p_grp_lz;
            if (p_grp_lz > p_ngrp - CNT_W'(1)) begin
                p_skip = p_ngrp - CNT_W'(1);
            end
        end
    end

    div_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_div_step (
        .rmd_i  (rmd_q),
        .dq_i   (dq_q),
        .dvsr_i (dvsr_q),
        .rmd_o  (step_rmd),
        .dq_o   (step_dq)
    );

    assign q_raw = (special_q | ~quo_neg_q) ? dq_q : -dq_q;
    assign r_raw = (special_q | ~rmd_neg_q) ? rmd_q : -rmd_q;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        rmd_d     = rmd_q;
        dq_d      = dq_q;
        dvsr_d    = dvsr_q;
        cnt_d     = cnt_q;
        quo_neg_d = quo_neg_q;
        rmd_neg_d = rmd_neg_q;
        special_d = special_q;
        res_quo_d = res_quo_q;
        res_rmd_d = res_rmd_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d         = PREP;
                    req_d.int_32    = int_32_i;
                    req_d.signed_op = signed_op_i;
                    req_d.dvnd      = DIV_MAX_XLEN'(dvnd_i);
                    req_d.dvsr      = DIV_MAX_XLEN'(dvsr_i);
                end
            end
            PREP: begin
                quo_neg_d = p_dvnd_neg ^ p_dvsr_neg;
                rmd_neg_d = p_dvnd_neg;
                dvsr_d    = p_dvsr_abs;
                special_d = p_div0 | p_ovf;
                if (p_div0) begin
                    dq_d    = '1;
                    rmd_d   = p_dvnd_e;
                    state_d = FIX;
                end else if (p_ovf) begin
                    dq_d    = p_dvnd_e;
                    rmd_d   = '0;
                    state_d = FIX;
                end else begin
                    dq_d    = p_aligned << (p_skip * BITS_PER_CYCLE);
                    rmd_d   = '0;
                    cnt_d   = p_ngrp - p_skip;
                    state_d = ITER;
                end
            end
            ITER: begin
                // Counter exhausted: a closing cycle before sign fix-up.
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    rmd_d = step_rmd;
                    dq_d  = step_dq;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                res_quo_d = w32 ? ext32(q_raw, 1'b1) : q_raw;
                res_rmd_d = w32 ? ext32(r_raw, 1'b1) : r_raw;
                state_d   = HOLD;
            end
            HOLD: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (kill_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            req_q     <= '0;
            rmd_q     <= '0;
            dq_q      <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            quo_neg_q <= 1'b0;
            rmd_neg_q <= 1'b0;
            special_q <= 1'b0;
            res_quo_q <= '0;
            res_rmd_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            rmd_q     <= rmd_d;
            dq_q      <= dq_d;
            dvsr_q    <= dvsr_d;
            cnt_q     <= cnt_d;
            quo_neg_q <= quo_neg_d;
            rmd_neg_q <= rmd_neg_d;
            special_q <= special_d;
            res_quo_q <= res_quo_d;
            res_rmd_q <= res_rmd_d;
        end
    end

endmodule
